// File: rtl/pipe_stage_elastic_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic_if
//   One side of an elastic pipeline handshake: valid/ready plus a control
//   field and a payload field.
//
//   Handshake: the master drives valid, ctrl and data. The slave drives
//   ready. An entry transfers on a rising clock edge where valid and ready
//   are both 1. While valid=1 and ready=0 the master holds ctrl and data
//   stable. While valid=0, ctrl and data carry no meaning.
//
//   Parameters: CTRL_W control width, DATA_W payload width.
//   Modports  : master (drives valid/ctrl/data), slave (drives ready).
// ---------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 165
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic pipeline stage register with a 2-entry skid buffer. It sits
//   between two pipeline stages and gives 1-cycle latency and
//   1 entry/cycle throughput. in_ready is decoded from registered state
//   only, so back-pressure never forms a combinational path across stages.
//   The control field is zero whenever no entry is presented (a NOP
//   bubble), and so is the payload.
//
//   Ports:
//     clock        rising-edge clock
//     reset        synchronous, active-high; takes priority over flush
//     flush        synchronous kill of held entries and of the entry offered
//                  in the same cycle
//     in_if        upstream handshake (slave side): valid/ready/ctrl/data
//     out_if       downstream handshake (master side): valid/ready/ctrl/data
//     count        occupancy, 0..2
//     stall_cycles cycles with out valid and not ready (performance counter)
//     flush_drops  entries discarded by flush (performance counter)
//     dbg_state_o  current FSM state (EMPTY=0, ONE=1, TWO=2)
//
//   Optional feature macro: PIPE_STAGE_PERF_EN builds the two performance
//   counters. Without it both counters are tied to zero.
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 165
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    pipe_stage_elastic_if.slave         in_if,
    pipe_stage_elastic_if.master        out_if,
    output logic [1:0]                  count,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 flush_drops,
    output logic [1:0]                  dbg_state_o
);

    // The state encoding equals the occupancy, so count is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_ready;
    logic out_valid;
    logic acc;
    logic pop;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_if.valid & in_ready;
    assign pop       = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    // main is cleared whenever the stage empties, so the outputs read zero
    // while out_valid=0 without any output gating.
    assign out_if.ctrl  = main_ctrl_q;
    assign out_if.data  = main_data_q;

    assign count       = state_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // A pop in this cycle still completes downstream; everything
            // else, including the offered entry, is dropped.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d     = ONE;
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_if.ctrl;
                        skid_data_d = in_if.data;
                    end else if (!acc && pop) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                        main_data_d = '0;
                    end else if (acc && pop) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move state.
                    if (pop) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    main_data_d = '0;
                    skid_ctrl_d = '0;
                    skid_data_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] drops_q, drops_d;

    always_comb begin
        stall_d = stall_q;
        drops_d = drops_q;
        if (out_valid && !out_if.ready) begin
            stall_d = stall_q + 32'd1;
        end
        // Dropped on flush: held entries not leaving via pop, plus the
        // entry offered this cycle (0..3).
        if (flush) begin
            drops_d = drops_q + 32'(count) - 32'(pop) + 32'(in_if.valid);
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            stall_q <= stall_d;
            drops_q <= drops_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_drops  = drops_q;
`else
    assign stall_cycles = '0;
    assign flush_drops  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//   Bench for pipe_stage_elastic. The reference is an entry queue of
//   capacity 2: entries enter when offered with space available, leave from
//   the front when presented and accepted, and a flush empties the queue.
//   Directed scenarios pin exact values, then a random phase runs against
//   the same reference.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 165;
    localparam int ENT_W  = CTRL_W + DATA_W;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) in_if ();
    pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) out_if ();

    logic [1:0]  count;
    logic [31:0] stall_cycles;
    logic [31:0] flush_drops;
    logic [1:0]  dbg_state;

    pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_if        (in_if),
        .out_if       (out_if),
        .count        (count),
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference: ordered entries held by the stage, plus counter models.
    logic [ENT_W-1:0] exp_q[$];
    int unsigned      m_stall = 0;
    int unsigned      m_drops = 0;
    bit               started = 1'b0;

    always @(posedge clock) begin
        bit pop_m;
        bit acc_m;
        if (reset) begin
            exp_q.delete();
            m_stall = 0;
            m_drops = 0;
        end else begin
            pop_m = (exp_q.size() != 0) && out_if.ready;
            acc_m = in_if.valid && (exp_q.size() < 2);
            if ((exp_q.size() != 0) && !out_if.ready) m_stall++;
            if (flush) begin
                m_drops = m_drops + exp_q.size() - (pop_m ? 1 : 0) + (in_if.valid ? 1 : 0);
                exp_q.delete();
            end else begin
                if (pop_m) void'(exp_q.pop_front());
                if (acc_m) exp_q.push_back({in_if.ctrl, in_if.data});
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic [ENT_W-1:0] head;
        bit               v;
        if (started) begin
            v    = (exp_q.size() != 0);
            head = v ? exp_q[0] : '0;
            check("out_valid", out_if.valid, v);
            check("in_ready", in_if.ready, exp_q.size() < 2);
            check("count", count, exp_q.size());
            check("dbg_state", dbg_state, exp_q.size());
            check("out_ctrl", out_if.ctrl, head[ENT_W-1:DATA_W]);
            check("out_data", out_if.data, head[DATA_W-1:0]);
            check("stall_cycles", stall_cycles, PERF ? m_stall : 0);
            check("flush_drops", flush_drops, PERF ? m_drops : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_if.valid = v;
        in_if.ctrl  = c;
        in_if.data  = d;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W; k++) r[k] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        out_if.ready = 1'b0;
        offer(1'b0, '0, '0);
        tick();
        tick();
        check("rst_out_valid", out_if.valid, 0);
        check("rst_in_ready", in_if.ready, 1);
        check("rst_count", count, 0);
        reset = 1'b0;

        // Streaming: 1-cycle latency, count stays 1.
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 9'h1A5, DATA_W'(i * 4));
            tick();
            check("stream_valid", out_if.valid, 1);
            check("stream_ctrl", out_if.ctrl, 9'h1A5);
            check("stream_pc", out_if.data, i * 4);
            check("stream_count", count, 1);
            check("stream_in_ready", in_if.ready, 1);
        end
        offer(1'b0, '0, '0);
        tick();
        check("stream_drain", count, 0);

        // Back-pressure: A, B fill, C waits upstream.
        out_if.ready = 1'b0;
        offer(1'b1, 9'h011, DATA_W'(32'hA));
        tick();
        offer(1'b1, 9'h022, DATA_W'(32'hB));
        tick();
        check("bp_count_two", count, 2);
        check("bp_in_ready_low", in_if.ready, 0);
        offer(1'b1, 9'h033, DATA_W'(32'hC));
        tick();
        check("bp_hold_A", out_if.data, 32'hA);
        tick();
        check("bp_hold_A2", out_if.data, 32'hA);
        out_if.ready = 1'b1;
        tick();
        check("bp_emit_B", out_if.data, 32'hB);
        tick();
        check("bp_emit_C", out_if.data, 32'hC);
        offer(1'b0, '0, '0);
        tick();
        check("bp_empty", out_if.valid, 0);
        check("bp_stall_len", stall_cycles, PERF ? 3 : 0);

        // Flush while TWO with an offer pending: everything dropped.
        out_if.ready = 1'b0;
        offer(1'b1, 9'h044, DATA_W'(32'hD));
        tick();
        offer(1'b1, 9'h055, DATA_W'(32'hE));
        tick();
        offer(1'b1, 9'h066, DATA_W'(32'hF));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        check("fl2_valid", out_if.valid, 0);
        check("fl2_ctrl", out_if.ctrl, 0);
        check("fl2_data", out_if.data, 0);
        check("fl2_count", count, 0);
        check("fl2_in_ready", in_if.ready, 1);
        check("fl2_drops", flush_drops, PERF ? 3 : 0);
        out_if.ready = 1'b1;
        tick();
        tick();
        check("fl2_no_ghost", out_if.valid, 0);

        // Flush with simultaneous pop from ONE, new entry offered.
        offer(1'b1, 9'h077, DATA_W'(32'h10));
        tick();
        offer(1'b1, 9'h088, DATA_W'(32'h11));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        check("flpop_count", count, 0);
        check("flpop_drops", flush_drops, PERF ? 4 : 0);

        // Reset mid-stream in TWO.
        out_if.ready = 1'b0;
        offer(1'b1, 9'h099, DATA_W'(32'h20));
        tick();
        offer(1'b1, 9'h0AA, DATA_W'(32'h21));
        tick();
        check("pre_rst_two", count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", out_if.valid, 0);
        check("mrst_data", out_if.data, 0);
        check("mrst_in_ready", in_if.ready, 1);
        check("mrst_stall", stall_cycles, 0);
        check("mrst_drops", flush_drops, 0);
        out_if.ready = 1'b1;
        offer(1'b1, 9'h0BB, DATA_W'(32'h30));
        tick();
        offer(1'b0, '0, '0);
        check("post_rst_first", out_if.data, 32'h30);

        // Random phase against the reference queue.
        for (int n = 0; n < 3000; n++) begin
            offer(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom), rnd_data());
            out_if.ready = 1'($urandom_range(0, 2) != 0);
            flush        = 1'($urandom_range(0, 31) == 0);
            reset        = 1'($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        offer(1'b0, '0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed ID/EXE stage register.
- Elastic pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer, so back-pressure does not create a combinational ready path across stages.
- Separate control field, zeroed into a bubble on flush or empty, and a data field.
- Sits between any two pipeline stages (ID/EXE, EXE/MEM, MEM/WB).

Parameters:
- CTRL_W, 9, control bits: wb_en, mem_read, mem_write, branch_type[1:0], exe_cmd[3:0]; all-zero is a NOP.
- DATA_W, 165, payload bits: pc, instruction, reg2, alu_inp1, alu_inp2, dest.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control field; zero whenever out_valid=0.
- out_data  out  DATA_W  payload; zero whenever out_valid=0.
- count  out  2  occupancy, 0..2.
- stall_cycles  out  32  perf counter (see Optional Feature).
- flush_drops  out  32  perf counter (see Optional Feature).

Behaviour:
- Storage:
  - main register drives out_*.
  - skid register holds a second entry.
  - FSM states: EMPTY (count=0), ONE (count=1), TWO (count=2).
- Events:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Outputs are decoded from registers only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Reset:
  - state=EMPTY, count=0, main/skid ctrl and data=0.
  - out_valid=0, in_ready=1, counters=0.
- Transitions, applied only when reset=0 and flush=0:
  - EMPTY: acc -> ONE, main<=in.
  - ONE, acc & ~pop -> TWO, skid<=in.
  - ONE, ~acc & pop -> EMPTY, main<=0.
  - ONE, acc & pop -> ONE, main<=in.
  - ONE, neither -> hold.
  - TWO: pop -> ONE, main<=skid, skid<=0. acc is impossible (in_ready=0).
  - TWO, no pop -> hold.
- Latency and throughput: 1 cycle from input to output when EMPTY; sustained throughput 1 entry/cycle when out_ready=1 (remains in ONE).
- Ordering: strictly FIFO; the skid entry is never emitted before main.
- Flush:
  - Priority: reset > flush > normal operation.
  - Next cycle: state=EMPTY, main/skid=0 (bubble), in_ready=1.
  - The in_* entry offered in the flush cycle is dropped, even though in_ready=1 in that cycle.
  - A pop in the flush cycle still completes downstream; the entry is not counted as dropped.
- Hold: with out_valid=1 and out_ready=0, out_ctrl and out_data stay stable until pop; AXI-style rule.
- Upstream contract: in_ctrl and in_data may change freely while in_valid=0.
- Reset mid-operation: all entries are discarded; no partial state survives.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with out_valid=1 & out_ready=0.
  - flush_drops adds, on each flush cycle, count minus (pop?1:0) plus (in_valid?1:0); range 0..3.
  - Both counters wrap modulo 2^32 and are cleared by reset only; flush does not clear them.
- Undefined: no counter logic is built; stall_cycles and flush_drops are tied to 0.

Test Plan:
- Streaming: out_ready=1; in_valid=1 for 4 cycles with in_ctrl=9'h1A5 and in_data = pc 0,4,8,12 -> out_valid from cycle 1 for 4 cycles, pc 0,4,8,12 in order; count stays 1; in_ready stays 1.
- Back-pressure: out_ready=0; send A, B, then offer C -> count=2, in_ready=0 after B and C is held upstream. Release out_ready -> A, B, C emerge in order, one per cycle; out_data stable while stalled. With the macro defined, stall_cycles equals the stall length.
- Flush in TWO: state TWO, in_valid=1, out_ready=0; pulse flush -> next cycle out_valid=0, out_ctrl=0, out_data=0, count=0, in_ready=1; no entry appears later. With the macro defined, flush_drops=3.
- Flush with simultaneous pop: state ONE, out_ready=1, flush=1 -> current entry accepted downstream, next cycle EMPTY. With the macro defined, flush_drops=0 (in_valid=0) or 1 (in_valid=1).
- Reset: reset asserted mid-stream in state TWO -> next edge all outputs zero, in_ready=1, counters 0. First entry after reset deasserts appears 1 cycle after it is accepted.
- Macro undefined: repeat the back-pressure and flush scenarios -> stall_cycles and flush_drops read 0 throughout; datapath behaviour is identical.
